// File: rtl/dispenser_pkg.sv
// Shared types and constants for the change dispenser.
//   disp_state_e : payout FSM states
//   coin_e       : hopper / coin identifiers (matches refill_coin encoding)
//   VAL_*        : coin values in nickel units
package dispenser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    DRIVE  = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } disp_state_e;

  typedef enum logic [1:0] {
    NICKEL  = 2'd0,
    DIME    = 2'd1,
    QUARTER = 2'd2
  } coin_e;

  localparam int VAL_N = 1;
  localparam int VAL_D = 2;
  localparam int VAL_Q = 5;

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the vending controller (master) and the change dispenser (slave).
//   req_valid/req_amount/req_ready : change request handshake
//   hop_quarter/hop_dime/hop_nickel: hopper motor enables
//   coin_drop                      : drop-sensor pulse from the active hopper
//   refill_valid/coin/count        : inventory top-up
//   inv_q/inv_d/inv_n              : hopper inventories
//   done/error/jam/short_amount    : completion report
//   dbg_state                      : current FSM state, for observation only
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. The source holds req_valid and req_amount stable
// until that edge; req_ready never depends combinationally on req_valid.
interface change_dispenser_if
  import dispenser_pkg::*;
#(
  parameter int AMT_W = 5,
  parameter int CNT_W = 8
) ();
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             hop_quarter;
  logic             hop_dime;
  logic             hop_nickel;
  logic             coin_drop;
  logic             refill_valid;
  logic [1:0]       refill_coin;
  logic [CNT_W-1:0] refill_count;
  logic [CNT_W-1:0] inv_q;
  logic [CNT_W-1:0] inv_d;
  logic [CNT_W-1:0] inv_n;
  logic             done;
  logic             error;
  logic             jam;
  logic [AMT_W-1:0] short_amount;
  disp_state_e      dbg_state;

  modport master (
    output req_valid, req_amount, coin_drop, refill_valid, refill_coin, refill_count,
    input  req_ready, hop_quarter, hop_dime, hop_nickel, inv_q, inv_d, inv_n,
           done, error, jam, short_amount, dbg_state
  );

  modport slave (
    input  req_valid, req_amount, coin_drop, refill_valid, refill_coin, refill_count,
    output req_ready, hop_quarter, hop_dime, hop_nickel, inv_q, inv_d, inv_n,
           done, error, jam, short_amount, dbg_state
  );
endinterface

// File: rtl/coin_inventory.sv
// One hopper's coin count: saturating up (refill) / down (coin paid) counter.
//   clock, reset : clock, async active-low reset (loads INIT)
//   dec          : one coin left this hopper
//   inc_valid    : add inc_count coins
//   count        : current inventory
module coin_inventory #(
  parameter int CNT_W = 8,
  parameter int INIT  = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec,
  input  logic             inc_valid,
  input  logic [CNT_W-1:0] inc_count,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   sum;

  // One spare bit holds count + refill before saturation, so a refill and a
  // payout on the same edge net out as count + inc_count - 1.
  always_comb begin
    sum = {1'b0, count_q} + (inc_valid ? {1'b0, inc_count} : '0);
    if (dec && (sum != '0)) sum = sum - ONE;
    count_d = (sum > MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= CNT_W'(INIT);
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/change_dispenser.sv
// Coin-payout back end: accepts a change request in nickel units and pays it
// greedily (quarter, dime, nickel), one coin per drop-sensor confirmation.
//   clock, reset : clock, async active-low reset
//   bus          : change_dispenser_if slave (request, motors, drop sensor,
//                  refill, inventories, done/error report, debug state)
module change_dispenser
  import dispenser_pkg::*;
#(
  parameter int AMT_W   = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16,
  parameter int INIT_Q  = 20,
  parameter int INIT_D  = 20,
  parameter int INIT_N  = 20
) (
  input logic                clock,
  input logic                reset,
  change_dispenser_if.slave  bus
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [AMT_W-1:0] V_Q = AMT_W'(VAL_Q);
  localparam logic [AMT_W-1:0] V_D = AMT_W'(VAL_D);
  localparam logic [AMT_W-1:0] V_N = AMT_W'(VAL_N);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  coin_e            coin_sel_q, coin_sel_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             jam_q, jam_d;
  logic [AMT_W-1:0] coin_val;
  logic             drop_ok;

  always_comb begin
    case (coin_sel_q)
      QUARTER: coin_val = V_Q;
      DIME:    coin_val = V_D;
      default: coin_val = V_N;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_sel_d  = coin_sel_q;
    tmr_d       = tmr_q;
    jam_d       = jam_q;
    drop_ok     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          remaining_d = bus.req_amount;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        tmr_d = '0;
        // Greedy pick; a coin is only chosen when its hopper is non-empty,
        // which is what keeps the inventories from underflowing.
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (remaining_q >= V_Q && bus.inv_q != '0) begin
          coin_sel_d = QUARTER;
          state_d    = DRIVE;
        end else if (remaining_q >= V_D && bus.inv_d != '0) begin
          coin_sel_d = DIME;
          state_d    = DRIVE;
        end else if (bus.inv_n != '0) begin
          coin_sel_d = NICKEL;
          state_d    = DRIVE;
        end else begin
          jam_d   = 1'b0;
          state_d = FAULT;
        end
      end
      DRIVE: begin
        if (bus.coin_drop) begin
          drop_ok     = 1'b1;
          remaining_d = remaining_q - coin_val;
          state_d     = SELECT;
        end else if (tmr_q == TMR_LAST) begin
          jam_d   = 1'b1;
          state_d = FAULT;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      coin_sel_q  <= NICKEL;
      tmr_q       <= '0;
      jam_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_sel_q  <= coin_sel_d;
      tmr_q       <= tmr_d;
      jam_q       <= jam_d;
    end
  end

  // Moore outputs: motors decode straight from the state flops, so an
  // asynchronous reset stops them without waiting for a clock edge.
  assign bus.req_ready    = (state_q == IDLE);
  assign bus.hop_quarter  = (state_q == DRIVE) && (coin_sel_q == QUARTER);
  assign bus.hop_dime     = (state_q == DRIVE) && (coin_sel_q == DIME);
  assign bus.hop_nickel   = (state_q == DRIVE) && (coin_sel_q == NICKEL);
  assign bus.done         = (state_q == DONE);
  assign bus.error        = (state_q == FAULT);
  assign bus.jam          = (state_q == FAULT) && jam_q;
  assign bus.short_amount = (state_q == FAULT) ? remaining_q : '0;
  assign bus.dbg_state    = state_q;

  coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_Q)) u_inv_q (
    .clock     (clock),
    .reset     (reset),
    .dec       (drop_ok && (coin_sel_q == QUARTER)),
    .inc_valid (bus.refill_valid && (bus.refill_coin == QUARTER)),
    .inc_count (bus.refill_count),
    .count     (bus.inv_q)
  );

  coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_D)) u_inv_d (
    .clock     (clock),
    .reset     (reset),
    .dec       (drop_ok && (coin_sel_q == DIME)),
    .inc_valid (bus.refill_valid && (bus.refill_coin == DIME)),
    .inc_count (bus.refill_count),
    .count     (bus.inv_d)
  );

  coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_N)) u_inv_n (
    .clock     (clock),
    .reset     (reset),
    .dec       (drop_ok && (coin_sel_q == NICKEL)),
    .inc_valid (bus.refill_valid && (bus.refill_coin == NICKEL)),
    .inc_count (bus.refill_count),
    .count     (bus.inv_n)
  );
endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed requests with hand-computed
// payout results, checked by a scoreboard monitor on the falling edge.
module tb_change_dispenser;
  import dispenser_pkg::*;

  localparam int AMT_W   = 5;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

  change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
    .INIT_Q(20), .INIT_D(20), .INIT_N(20)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          hop_rises = 0;
  logic [31:0] exp_q[$];      // {done, error, jam, short[4:0], inv_q, inv_d, inv_n}
  logic [1:0]  coin_exp_q[$]; // expected coin order, coin_e encoding

  function automatic logic [31:0] pack_res(input logic dn, input logic er, input logic jm,
                                           input logic [4:0] sh, input logic [7:0] q,
                                           input logic [7:0] d, input logic [7:0] n);
    return {dn, er, jm, sh, q, d, n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected event", name);
  endtask

  // ---------------- monitor ----------------
  logic [2:0] hop_prev = 3'b000;
  always @(negedge clock) begin
    logic [2:0]  hop_now;
    logic [2:0]  hop_exp;
    logic [1:0]  c;
    logic [31:0] act;
    hop_now = {bus.hop_quarter, bus.hop_dime, bus.hop_nickel};
    if (hop_now != 3'b000 && hop_prev == 3'b000) begin
      hop_rises++;
      if (coin_exp_q.size() == 0) begin
        check("unexpected motor", {29'd0, hop_now}, 32'd0);
      end else begin
        c = coin_exp_q.pop_front();
        hop_exp = (c == 2'd2) ? 3'b100 : (c == 2'd1) ? 3'b010 : 3'b001;
        check("coin order", {29'd0, hop_now}, {29'd0, hop_exp});
      end
    end
    hop_prev <= hop_now;
    if (bus.done || bus.error) begin
      act = pack_res(bus.done, bus.error, bus.jam, bus.short_amount,
                     bus.inv_q, bus.inv_d, bus.inv_n);
      if (exp_q.size() == 0) check("unexpected result", act, 32'd0);
      else                   check("result", act, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [4:0] amt);
    int w = 0;
    while (!bus.req_ready && w < 100) begin tick(); w++; end
    if (!bus.req_ready) bound_fail("req_ready");
    bus.req_valid  = 1'b1;
    bus.req_amount = amt;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  task automatic wait_hop(output bit ok);
    int w = 0;
    while (!(bus.hop_quarter || bus.hop_dime || bus.hop_nickel) && w < 64) begin
      tick();
      w++;
    end
    ok = bus.hop_quarter || bus.hop_dime || bus.hop_nickel;
    if (!ok) bound_fail("motor on");
  endtask

  task automatic drop_coins(input int n, input int dly);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_hop(ok);
      if (ok) begin
        repeat (dly) tick();
        bus.coin_drop = 1'b1;
        tick();
        bus.coin_drop = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!bus.req_ready && w < 64) begin tick(); w++; end
    if (!bus.req_ready) bound_fail("return to idle");
  endtask

  task automatic run_req(input logic [4:0] amt, input int nq, input int nd, input int nn,
                         input logic [31:0] exp);
    for (int i = 0; i < nq; i++) coin_exp_q.push_back(2'd2);
    for (int i = 0; i < nd; i++) coin_exp_q.push_back(2'd1);
    for (int i = 0; i < nn; i++) coin_exp_q.push_back(2'd0);
    exp_q.push_back(exp);
    send_req(amt);
    drop_coins(nq + nd + nn, 0);
    wait_idle();
  endtask

  task automatic pulse_reset();
    tick();
    #1 reset = 1'b0;
    tick();
    #2 reset = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int cnt;
    int r;
    bus.req_valid    = 1'b0;
    bus.req_amount   = '0;
    bus.coin_drop    = 1'b0;
    bus.refill_valid = 1'b0;
    bus.refill_coin  = 2'd0;
    bus.refill_count = '0;

    // Reset state
    repeat (3) tick();
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset motors", {29'd0, bus.hop_quarter, bus.hop_dime, bus.hop_nickel}, 32'd0);
    check("reset flags", {27'd0, bus.done, bus.error, bus.jam, 2'b00} | {27'd0, bus.short_amount}, 32'd0);
    check("reset inventory", {8'd0, bus.inv_q, bus.inv_d, bus.inv_n}, {8'd0, 8'd20, 8'd20, 8'd20});
    check("reset state", {29'd0, bus.dbg_state}, {29'd0, IDLE});
    #2 reset = 1'b1;
    tick();

    // 1. Request 8 from full stock: Q, D, N with drops 3 cycles after motor-on
    coin_exp_q.push_back(2'd2);
    coin_exp_q.push_back(2'd1);
    coin_exp_q.push_back(2'd0);
    exp_q.push_back(pack_res(1, 0, 0, 5'd0, 8'd19, 8'd19, 8'd19));
    send_req(5'd8);
    check("motor off in select", {29'd0, bus.hop_quarter, bus.hop_dime, bus.hop_nickel}, 32'd0);
    tick();
    check("first motor latency", {31'd0, bus.hop_quarter}, 32'd1);
    drop_coins(3, 3);
    wait_idle();

    // 2. Request 0: done with no motor activity
    r = hop_rises;
    exp_q.push_back(pack_res(1, 0, 0, 5'd0, 8'd19, 8'd19, 8'd19));
    send_req(5'd0);
    tick();
    check("zero request done latency", {31'd0, bus.done}, 32'd1);
    wait_idle();
    check("zero request motor count", hop_rises, r);

    // 6. Reset mid-payout: motors stop without a clock edge, inventories reload
    coin_exp_q.push_back(2'd2);
    send_req(5'd12);
    wait_hop(ok);
    tick();
    #2 reset = 1'b0;
    #1;
    check("motors stop in reset", {29'd0, bus.hop_quarter, bus.hop_dime, bus.hop_nickel}, 32'd0);
    tick();
    #2 reset = 1'b1;
    tick();
    check("ready after reset", {31'd0, bus.req_ready}, 32'd1);
    check("inventory after reset", {8'd0, bus.inv_q, bus.inv_d, bus.inv_n}, {8'd0, 8'd20, 8'd20, 8'd20});

    // 5a. Quarter refill +10 on the same edge as a quarter drop: 20 + 10 - 1
    coin_exp_q.push_back(2'd2);
    exp_q.push_back(pack_res(1, 0, 0, 5'd0, 8'd29, 8'd20, 8'd20));
    send_req(5'd5);
    wait_hop(ok);
    bus.coin_drop    = 1'b1;
    bus.refill_valid = 1'b1;
    bus.refill_coin  = 2'd2;
    bus.refill_count = 8'd10;
    tick();
    bus.coin_drop    = 1'b0;
    bus.refill_valid = 1'b0;
    check("refill with same-edge drop", {24'd0, bus.inv_q}, 32'd29);
    wait_idle();

    // 5b. Saturating refill, ignored coin code 3, drop while idle ignored
    bus.refill_valid = 1'b1;
    bus.refill_coin  = 2'd2;
    bus.refill_count = 8'd255;
    tick();
    bus.refill_valid = 1'b0;
    check("refill saturates", {24'd0, bus.inv_q}, 32'd255);
    bus.refill_valid = 1'b1;
    bus.refill_coin  = 2'd3;
    bus.refill_count = 8'd7;
    bus.coin_drop    = 1'b1;
    tick();
    bus.refill_valid = 1'b0;
    bus.coin_drop    = 1'b0;
    check("coin 3 and idle drop ignored", {8'd0, bus.inv_q, bus.inv_d, bus.inv_n},
          {8'd0, 8'd255, 8'd20, 8'd20});
    check("idle drop keeps idle", {31'd0, bus.req_ready}, 32'd1);

    // 4. Request 5 with no drop: 16 motor cycles then jam
    coin_exp_q.push_back(2'd2);
    exp_q.push_back(pack_res(0, 1, 1, 5'd5, 8'd255, 8'd20, 8'd20));
    send_req(5'd5);
    wait_hop(ok);
    cnt = 0;
    while (bus.hop_quarter && cnt < 64) begin cnt++; tick(); end
    check("jam motor-on cycles", cnt, TIMEOUT);
    wait_idle();

    // Drain to q=0, d=0, n=4 from a fresh reset, then 3. shortfall
    pulse_reset();
    check("inventory after second reset", {8'd0, bus.inv_q, bus.inv_d, bus.inv_n},
          {8'd0, 8'd20, 8'd20, 8'd20});
    run_req(5'd30, 6, 0, 0,  pack_res(1, 0, 0, 5'd0, 8'd14, 8'd20, 8'd20));
    run_req(5'd30, 6, 0, 0,  pack_res(1, 0, 0, 5'd0, 8'd8,  8'd20, 8'd20));
    run_req(5'd30, 6, 0, 0,  pack_res(1, 0, 0, 5'd0, 8'd2,  8'd20, 8'd20));
    run_req(5'd10, 2, 0, 0,  pack_res(1, 0, 0, 5'd0, 8'd0,  8'd20, 8'd20));
    run_req(5'd30, 0, 15, 0, pack_res(1, 0, 0, 5'd0, 8'd0,  8'd5,  8'd20));
    run_req(5'd10, 0, 5, 0,  pack_res(1, 0, 0, 5'd0, 8'd0,  8'd0,  8'd20));
    run_req(5'd16, 0, 0, 16, pack_res(1, 0, 0, 5'd0, 8'd0,  8'd0,  8'd4));
    run_req(5'd7,  0, 0, 4,  pack_res(0, 1, 0, 5'd3, 8'd0,  8'd0,  8'd0));

    repeat (3) tick();
    check("pending results", exp_q.size(), 0);
    check("pending coins", coin_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
